// File: rtl/rvc_pkg.sv
// Shared types and helpers for the RVC fetch aligner.
//   halfword_t     : one 16-bit instruction parcel
//   BUF_HW_DEFAULT : default halfword buffer depth (minimum legal value 3)
//   ins_len_t      : length of the instruction at the head of the buffer
//   is_rvc()       : true when a parcel starts a compressed instruction
package rvc_pkg;

    typedef logic [15:0] halfword_t;

    localparam int BUF_HW_DEFAULT = 4;

    typedef enum logic {
        LEN16,
        LEN32
    } ins_len_t;

    // A parcel whose low two bits are not 2'b11 is a complete 16-bit instruction.
    function automatic logic is_rvc(input halfword_t hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/hw_queue.sv
// Halfword FIFO feeding the aligner's output selection.
//   clk, rst    : clock, asynchronous active-high reset
//   clear_i     : drop all entries (count becomes 0 next cycle)
//   push_cnt_i  : number of halfwords appended this cycle (0..2)
//   push_hw0_i  : first appended halfword, push_hw1_i: second
//   pop_cnt_i   : number of halfwords removed from the head (0..2)
//   count_o     : entries held
//   entry0_o    : oldest entry, entry1_o: next oldest
// Pops shift out before pushes append, so a full-rate push/pop pair works.
module hw_queue
    import rvc_pkg::*;
#(
    parameter  int DEPTH = BUF_HW_DEFAULT,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    input  logic [1:0]    push_cnt_i,
    input  halfword_t     push_hw0_i,
    input  halfword_t     push_hw1_i,
    input  logic [1:0]    pop_cnt_i,
    output logic [CW-1:0] count_o,
    output halfword_t     entry0_o,
    output halfword_t     entry1_o
);

    halfword_t     mem_q [DEPTH];
    halfword_t     mem_d [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] kept;

    // NOTE: every variable gets its value before any conditional update, so
    //       no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        kept = count_q - CW'(pop_cnt_i);
        for (int i = 0; i < DEPTH; i++) begin
            if (i + int'(pop_cnt_i) < DEPTH) begin
                mem_d[i] = mem_q[i + int'(pop_cnt_i)];
            end else begin
                mem_d[i] = '0;
            end
            if (push_cnt_i != 2'd0 && i == int'(kept)) begin
                mem_d[i] = push_hw0_i;
            end
            if (push_cnt_i == 2'd2 && i == int'(kept) + 1) begin
                mem_d[i] = push_hw1_i;
            end
        end
        count_d = kept + CW'(push_cnt_i);
        if (clear_i) begin
            count_d = '0;
        end
    end

    // NOTE: the storage is reset along with the count so the peeked entries
    //       (and therefore out_ins) read as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            //       the pre-edge values regardless of statement order.
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign count_o  = count_q;
    assign entry0_o = mem_q[0];
    assign entry1_o = mem_q[1];

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Fetch sequencer and 16/32-bit instruction re-aligner.
//   clk, Rst         : clock, asynchronous active-high reset
//   fetch_req/_addr  : word request to instruction memory (addr[1:0] = 0)
//   fetch_valid/rdata: same-cycle response; [15:0] = addr, [31:16] = addr+2
//   out_valid/ready  : one whole instruction per cycle to decode
//   out_ins/pc       : instruction (compressed in [15:0], upper zero) and PC
//   out_compressed   : 16-bit instruction flag; out_zero: all-zero parcel
//   flush/redirect_pc: redirect, highest priority; redirect_pc[0] ignored
// Outputs come only from registers, so fetched data shows up the next cycle.
module rvc_fetch_aligner
    import rvc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = BUF_HW_DEFAULT
) (
    input  logic        clk,
    input  logic        Rst,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    output logic        out_compressed,
    output logic        out_zero,
    input  logic        flush,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(BUF_HW + 1);

    logic [31:0]   fetch_addr_q;
    logic [31:0]   out_pc_q;
    logic          skip_low_q;
    logic [CW-1:0] count;
    halfword_t     entry0;
    halfword_t     entry1;
    logic          accept;
    logic          consume;
    logic [1:0]    push_cnt;
    logic [1:0]    pop_cnt;
    ins_len_t      len;
    logic          unused_redirect_bit0;

    assign unused_redirect_bit0 = redirect_pc[0];

    // Requesting only with room for two halfwords keeps the buffer from
    // overflowing even though a full word may arrive in the same cycle.
    assign fetch_req = !flush && (int'(count) <= BUF_HW - 2);
    assign accept    = fetch_req && fetch_valid;
    assign push_cnt  = !accept ? 2'd0 : (skip_low_q ? 2'd1 : 2'd2);

    always_comb begin
        out_valid      = 1'b0;
        out_ins        = '0;
        out_compressed = 1'b0;
        len            = LEN16;
        if (!flush) begin
            if (count >= CW'(1) && is_rvc(entry0)) begin
                out_valid      = 1'b1;
                out_ins        = {16'h0000, entry0};
                out_compressed = 1'b1;
            end else if (count >= CW'(2)) begin
                out_valid = 1'b1;
                out_ins   = {entry1, entry0};
                len       = LEN32;
            end
        end
        out_zero = out_compressed && (out_ins[15:0] == 16'h0000);
    end

    assign consume = out_valid && out_ready;
    assign pop_cnt = !consume ? 2'd0 : ((len == LEN16) ? 2'd1 : 2'd2);

    hw_queue #(
        .DEPTH (BUF_HW)
    ) u_queue (
        .clk        (clk),
        .rst        (Rst),
        .clear_i    (flush),
        .push_cnt_i (push_cnt),
        .push_hw0_i (skip_low_q ? fetch_rdata[31:16] : fetch_rdata[15:0]),
        .push_hw1_i (fetch_rdata[31:16]),
        .pop_cnt_i  (pop_cnt),
        .count_o    (count),
        .entry0_o   (entry0),
        .entry1_o   (entry1)
    );

    // skip_low marks a halfword-aligned target: the low half of the first
    // word fetched after a redirect belongs to the previous code path.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            out_pc_q     <= RESET_PC;
            skip_low_q   <= RESET_PC[1];
        end else if (flush) begin
            fetch_addr_q <= {redirect_pc[31:2], 2'b00};
            out_pc_q     <= {redirect_pc[31:1], 1'b0};
            skip_low_q   <= redirect_pc[1];
        end else begin
            if (accept) begin
                fetch_addr_q <= fetch_addr_q + 32'd4;
                skip_low_q   <= 1'b0;
            end
            if (consume) begin
                out_pc_q <= out_pc_q + ((len == LEN16) ? 32'd2 : 32'd4);
            end
        end
    end

    assign fetch_addr = fetch_addr_q;
    assign out_pc     = out_pc_q;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Self-checking bench for rvc_fetch_aligner: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based model of the halfword stream.
module tb_rvc_fetch_aligner;
    import rvc_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          BUF_HW   = 4;

    logic        clk = 1'b0;
    logic        Rst;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        out_compressed;
    logic        out_zero;
    logic        flush;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    rvc_fetch_aligner #(
        .RESET_PC (RESET_PC),
        .BUF_HW   (BUF_HW)
    ) dut (
        .clk            (clk),
        .Rst            (Rst),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_valid    (fetch_valid),
        .fetch_rdata    (fetch_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .out_compressed (out_compressed),
        .out_zero       (out_zero),
        .flush          (flush),
        .redirect_pc    (redirect_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the buffered halfword stream plus the two addresses.
    halfword_t   mq[$];
    logic [31:0] m_faddr;
    logic [31:0] m_pc;
    logic        m_skip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
        end
    endtask

    // Apply inputs just after a falling edge; outputs settle by the #1.
    task automatic drive(input logic f, input logic [31:0] rp, input logic fv,
                         input logic [31:0] rd, input logic rdy);
        flush       = f;
        redirect_pc = rp;
        fetch_valid = fv;
        fetch_rdata = rd;
        out_ready   = rdy;
        #1;
    endtask

    // Compare DUT against the model, advance the model by one clock, and
    // move to the next falling edge.
    task automatic tick();
        logic        e_req;
        logic        e_valid;
        logic        e_comp;
        logic        e_zero;
        logic [31:0] e_ins;
        int          n;
        e_req   = !flush && (mq.size() <= BUF_HW - 2);
        e_valid = 1'b0;
        e_comp  = 1'b0;
        e_ins   = 32'h0;
        n       = 0;
        if (!flush) begin
            if (mq.size() >= 1 && mq[0][1:0] != 2'b11) begin
                e_valid = 1'b1;
                e_comp  = 1'b1;
                e_ins   = {16'h0000, mq[0]};
                n       = 1;
            end else if (mq.size() >= 2) begin
                e_valid = 1'b1;
                e_ins   = {mq[1], mq[0]};
                n       = 2;
            end
        end
        e_zero = e_comp && (e_ins[15:0] == 16'h0000);

        check("m_fetch_req",  {31'h0, fetch_req},      {31'h0, e_req});
        check("m_fetch_addr", fetch_addr,              m_faddr);
        check("m_out_valid",  {31'h0, out_valid},      {31'h0, e_valid});
        check("m_out_ins",    out_ins,                 e_ins);
        check("m_out_pc",     out_pc,                  m_pc);
        check("m_out_comp",   {31'h0, out_compressed}, {31'h0, e_comp});
        check("m_out_zero",   {31'h0, out_zero},       {31'h0, e_zero});

        if (flush) begin
            mq.delete();
            m_faddr = {redirect_pc[31:2], 2'b00};
            m_skip  = redirect_pc[1];
            m_pc    = {redirect_pc[31:1], 1'b0};
        end else begin
            if (e_valid && out_ready) begin
                repeat (n) void'(mq.pop_front());
                m_pc = m_pc + 32'(2 * n);
            end
            if (e_req && fetch_valid) begin
                if (!m_skip) mq.push_back(fetch_rdata[15:0]);
                mq.push_back(fetch_rdata[31:16]);
                m_skip  = 1'b0;
                m_faddr = m_faddr + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    function automatic halfword_t rand_hw();
        halfword_t h;
        int        r;
        r = $urandom_range(7);
        h = 16'($urandom);
        if (r == 0) h = 16'h0000;
        else if (r < 4) h[1:0] = 2'b11;
        return h;
    endfunction

    initial begin
        Rst = 1'b1;
        flush = 1'b0; redirect_pc = 32'h0; fetch_valid = 1'b0;
        fetch_rdata = 32'h0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_ins",   out_ins, 32'h0);
        check("rst_out_comp",  {31'h0, out_compressed}, 32'h0);
        Rst = 1'b0;
        mq.delete();
        m_faddr = {RESET_PC[31:2], 2'b00};
        m_pc    = RESET_PC;
        m_skip  = RESET_PC[1];

        // Two compressed instructions in one word.
        drive(1'b0, 32'h0, 1'b1, 32'h4501_1141, 1'b1);
        check("rst_fetch_addr", fetch_addr, 32'h0);
        check("rst_fetch_req",  {31'h0, fetch_req}, 32'h1);
        check("rst_out_pc",     out_pc, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("c0_ins",   out_ins, 32'h0000_1141);
        check("c0_pc",    out_pc, 32'h0);
        check("c0_comp",  {31'h0, out_compressed}, 32'h1);
        check("c0_faddr", fetch_addr, 32'h4);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("c1_ins",  out_ins, 32'h0000_4501);
        check("c1_pc",   out_pc, 32'h2);
        check("c1_comp", {31'h0, out_compressed}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("c2_empty", {31'h0, out_valid}, 32'h0);
        tick();

        // Straddling 32-bit instruction.
        drive(1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h0093_4501, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("s0_ins", out_ins, 32'h0000_4501);
        check("s0_pc",  out_pc, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("s1_partial", {31'h0, out_valid}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0010, 1'b1);
        check("s2_partial", {31'h0, out_valid}, 32'h0);
        check("s2_faddr",   fetch_addr, 32'h4);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("s3_ins",  out_ins, 32'h0010_0093);
        check("s3_pc",   out_pc, 32'h2);
        check("s3_comp", {31'h0, out_compressed}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("z_ins",  out_ins, 32'h0);
        check("z_zero", {31'h0, out_zero}, 32'h1);
        check("z_pc",   out_pc, 32'h6);
        tick();

        // Backpressure with 32-bit instructions.
        drive(1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        check("f_forces_invalid", {31'h0, out_valid}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h00A0_0093, 1'b0);
        check("bp_req0", {31'h0, fetch_req}, 32'h1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 32'h00A0_0093, 1'b0);
            check("bp_req",  {31'h0, fetch_req}, (i == 0) ? 32'h1 : 32'h0);
            check("bp_ins",  out_ins, 32'h00A0_0093);
            check("bp_pc",   out_pc, 32'h200);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1, 32'h00A0_0093, 1'b1);
        check("bp_rel_req", {31'h0, fetch_req}, 32'h0);
        check("bp_rel_pc",  out_pc, 32'h200);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h00A0_0093, 1'b1);
        check("bp_resume_req", {31'h0, fetch_req}, 32'h1);
        check("bp_resume_pc",  out_pc, 32'h204);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("bp_end_pc",    out_pc, 32'h208);
        check("bp_end_faddr", fetch_addr, 32'h20C);
        tick();

        // Redirect to a halfword-aligned target.
        drive(1'b1, 32'h106, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h2345_8888, 1'b1);
        check("rd_faddr", fetch_addr, 32'h104);
        check("rd_pc",    out_pc, 32'h106);
        check("rd_req",   {31'h0, fetch_req}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("rd_ins",   out_ins, 32'h0000_2345);
        check("rd_pc2",   out_pc, 32'h106);
        check("rd_faddr2", fetch_addr, 32'h108);
        tick();

        // Flush with three buffered halfwords and a concurrent response.
        drive(1'b1, 32'h302, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h0093_AAAA, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h4501_00A0, 1'b0);
        check("fc_partial", {31'h0, out_valid}, 32'h0);
        tick();
        drive(1'b1, 32'h400, 1'b1, 32'h1111_2222, 1'b1);
        check("fc_valid", {31'h0, out_valid}, 32'h0);
        check("fc_req",   {31'h0, fetch_req}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("fc_after_valid", {31'h0, out_valid}, 32'h0);
        check("fc_after_pc",    out_pc, 32'h400);
        check("fc_after_req",   {31'h0, fetch_req}, 32'h1);
        tick();

        // Address wrap.
        drive(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h4501_0000, 1'b0);
        check("w_faddr", fetch_addr, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("w_faddr2", fetch_addr, 32'h0);
        check("w_ins",    out_ins, 32'h0000_4501);
        check("w_pc",     out_pc, 32'hFFFF_FFFE);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("w_pc2", out_pc, 32'h0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rp;
            rp = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                          : 32'($urandom);
            drive($urandom_range(15) == 0, rp, $urandom_range(3) != 0,
                  {rand_hw(), rand_hw()}, $urandom_range(2) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rvc_fetch_aligner.md
Name: rvc_fetch_aligner

Overview:
- Sits between the word-aligned instruction memory port and the decode stage, which holds the compressed decoder and the 32-bit decoder.
- Sequences fetch addresses and buffers halfwords from the fetched words.
- Re-aligns mixed 16/32-bit instruction streams and presents one whole instruction per cycle with its PC and a compressed flag.
- Handles control-flow redirects, including redirects to halfword-aligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch/instruction PC after reset; bit 0 must be 0.
- BUF_HW, 4, halfword buffer depth; minimum legal value 3.

Ports:
- clk  input  1  system clock
- Rst  input  1  asynchronous reset, active-high
- fetch_req  output  1  request the word at fetch_addr
- fetch_addr  output  32  word-aligned fetch address (bits [1:0] = 0)
- fetch_valid  input  1  fetch_rdata is valid for fetch_addr this cycle
- fetch_rdata  input  32  fetched word; halfword at addr is in [15:0], addr+2 is in [31:16]
- out_valid  output  1  out_ins holds a complete instruction
- out_ready  input  1  decode accepts the instruction (low = hazard stall)
- out_ins  output  32  instruction; a compressed instruction sits in [15:0] with [31:16] = 0
- out_pc  output  32  PC of out_ins
- out_compressed  output  1  out_ins[1:0] != 2'b11
- out_zero  output  1  compressed and out_ins[15:0] == 0; this drives the decoder's ins_zero
- flush  input  1  redirect request
- redirect_pc  input  32  redirect target; bit 0 is ignored

Behaviour:
- Reset (async, Rst=1):
  - count=0, buffer cleared.
  - fetch_addr={RESET_PC[31:2],2'b00}; out_pc=RESET_PC; skip_low=RESET_PC[1].
  - out_valid=0, out_ins=0, out_compressed=0, out_zero=0.
- State:
  - Halfword FIFO of BUF_HW entries. Entry 0 is the oldest.
  - count, range 0..BUF_HW.
  - skip_low flag, fetch_addr register, out_pc register.
- fetch_req = !flush && (count <= BUF_HW-2). It uses the registered count only; a same-cycle consume does not raise it.
- Fetch accept = fetch_req && fetch_valid. On accept:
  - fetch_addr += 4.
  - If skip_low: push only rdata[31:16] (count+1) and clear skip_low.
  - Otherwise push rdata[15:0] then rdata[31:16] (count+2).
- Output selection (combinational from registers):
  - If count>=1 and entry0[1:0]!=2'b11: out_valid=1, out_ins={16'h0,entry0}, out_compressed=1.
  - Else if count>=2: out_valid=1, out_ins={entry1,entry0}, out_compressed=0.
  - Else out_valid=0.
  - out_valid is forced to 0 while flush=1.
  - When out_valid=0, out_ins/out_compressed/out_zero are 0.
- Consume = out_valid && out_ready:
  - Pops 1 halfword (compressed) or 2 (32-bit).
  - out_pc += 2 or += 4 respectively.
- Simultaneous accept and consume:
  - count_next = count + pushed - popped.
  - Popped entries shift out before pushed entries append.
  - Never exceeds BUF_HW, by construction of fetch_req.
- Latency: a word accepted in cycle N can appear on out_ins in cycle N+1 at the earliest. There is no combinational path from fetch_rdata to out_*.
- Stall: while out_valid && !out_ready, out_ins/out_pc/out_compressed hold stable. Fetching continues until the buffer is full.
- Partial 32-bit instruction: count==1 with entry0[1:0]==2'b11 gives out_valid=0. The aligner waits for the next word; the instruction straddles the word boundary.
- Flush (priority over everything):
  - Next cycle count=0, no push, no pop.
  - fetch_addr={redirect_pc[31:2],2'b00}; skip_low=redirect_pc[1]; out_pc={redirect_pc[31:1],1'b0}.
  - A fetch_valid asserted in the flush cycle is ignored.
  - A flush held for several cycles re-applies each cycle.
- Address wrap: fetch_addr and out_pc wrap modulo 2^32 with no error.
- No epoch/tag logic is needed: the instruction memory returns data for the currently presented fetch_addr in the same cycle.

Decomposition:
- Package rvc_pkg:
  - halfword_t typedef (logic [15:0]).
  - BUF_HW default constant.
  - is_rvc function (returns hw[1:0] != 2'b11).
  - ins_len_t enum {LEN16, LEN32}.
- Sub-module hw_queue:
  - Parameterised halfword FIFO with push-1/push-2, pop-1/pop-2, clear, count output, and entry0/entry1 peek.
  - rvc_fetch_aligner owns the address, PC, skip_low and output-selection logic.

Test Plan:
- Reset with RESET_PC=0 -> fetch_addr=0, fetch_req=1, out_valid=0, out_pc=0.
- fetch_rdata=32'h4501_1141, out_ready=1 -> next cycle out_ins=32'h0000_1141 at pc 0x0, then 32'h0000_4501 at pc 0x2; out_compressed=1 both times; fetch_addr=0x4 after accept.
- Straddle case:
  - Stimulus: word0=32'h0093_4501, word1=32'h0000_0010.
  - Response: out 0x4501 at pc 0x0 (compressed); then out_valid=0 until word1 is accepted; then out_ins=32'h0010_0093 at pc 0x2 with out_compressed=0.
- Backpressure: out_ready=0 for 5 cycles with words of 32-bit instructions -> count reaches 4, fetch_req=0, out_ins/out_pc constant; raising out_ready resumes fetch the cycle after count drops to 2.
- Flush with redirect_pc=32'h0000_0106 -> fetch_addr=0x104; the first accepted word's [15:0] is dropped; the next output has out_pc=0x106 and out_ins from rdata[31:16].
- flush=1 in the same cycle as fetch_valid=1 and out_ready=1 with count=3 -> no pop, no push; next cycle count=0, out_valid=0, out_pc=redirect_pc; fetch_req=1.
